// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel button path of the clock.
// Purpose : FSM state encoding used by every button_event instance, plus the
//           nominal tick rate that the hold thresholds are expressed in.
// Ports   : none (package).
package clock_pkg;

  // Button FSM states, 2-bit encoding. The fourth code is unused and
  // recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  // Nominal tick strobe rate in Hz. With this rate LONG_TICKS and
  // REPEAT_TICKS read directly as milliseconds.
  localparam int TICK_HZ = 1000;

endpackage

// File: rtl/btn_edge.sv
// Registered copy of the debounced button level with edge detection.
// Purpose : holds btn for one cycle and flags rising/falling transitions
//           relative to that registered copy.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset (clears the level to 0)
//           btn   - debounced button level, clk-synchronous
//           level - btn delayed by one cycle
//           rise  - combinational, btn high while level is low
//           fall  - combinational, btn low while level is high
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
    end else begin
      level <= btn;
    end
  end

  assign rise = btn & ~level;
  assign fall = ~btn & level;

endmodule

// File: rtl/button_event.sv
// Turns one debounced push-button level into single-cycle user events.
// Purpose : press, short release, long-press detect and auto-repeat pulses
//           for the time/alarm setting logic. Hold times are counted in tick
//           enables so they do not depend on the cclk frequency.
// Ports   : cclk      - system clock, rising edge
//           clr_n     - asynchronous active-low reset, released synchronously
//           tick      - one-cycle timebase enable
//           btn       - debounced button level, active-high
//           press     - pulse: button went down
//           short_rel - pulse: released before long_det fired
//           long_det  - pulse: hold reached LONG_TICKS
//           rep       - pulse: every REPEAT_TICKS while held after long_det
//           held      - level: registered btn
module button_event
  import clock_pkg::*;
#(
  parameter int CNT_W        = 11,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic cclk,
  input  logic clr_n,
  input  logic tick,
  input  logic btn,
  output logic press,
  output logic short_rel,
  output logic long_det,
  output logic rep,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic             rst_n;
  logic             btn_q;
  logic             rise;
  logic             fall;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             short_rel_d;
  logic             long_det_d;
  logic             rep_d;

  // Reset asserts immediately through clr_n but is released on a clock edge,
  // so the first active cycle after release is one edge later.
  always_ff @(posedge cclk or negedge clr_n) begin
    if (!clr_n) begin
      rst_n <= 1'b0;
    end else begin
      rst_n <= 1'b1;
    end
  end

  btn_edge u_edge (
    .clk   (cclk),
    .rst_n (rst_n),
    .btn   (btn),
    .level (btn_q),
    .rise  (rise),
    .fall  (fall)
  );

  assign held = btn_q;

  // Next-state logic. A fall is checked before the tick so a release that
  // coincides with a terminal tick always wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    short_rel_d = 1'b0;
    long_det_d  = 1'b0;
    rep_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d     = IDLE;
          cnt_d       = '0;
          short_rel_d = 1'b1;
        end else if (tick) begin
          if (cnt_q == LONG_LAST) begin
            state_d    = LONG;
            cnt_d      = '0;
            long_det_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == REP_LAST) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, hold counter and registered event pulses.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press     <= 1'b0;
      short_rel <= 1'b0;
      long_det  <= 1'b0;
      rep       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press     <= press_d;
      short_rel <= short_rel_d;
      long_det  <= long_det_d;
      rep       <= rep_d;
    end
  end

endmodule
